// File: rtl/efpga_cfg_pkg.sv
// Shared configuration constants and FSM state type for the eFPGA config path.
package efpga_cfg_pkg;

    localparam int CFG_WORD_W    = 16;
    localparam int CFG_NUM_WORDS = 32;
    localparam int CFG_NUM_SLOTS = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        LATCH,
        RUN
    } cfg_state_t;

endpackage

// File: rtl/cfg_shifter.sv
// Parallel-load, MSB-first shift register with a per-word bit counter.
module cfg_shifter #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    output logic              msb,
    output logic              last_bit
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;

    // Capture a fresh word on load, otherwise move one bit toward the MSB per shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= word;
            bit_cnt <= '0;
        end else if (shift) begin
            shreg   <= {shreg[WORD_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign msb      = shreg[WORD_W-1];
    assign last_bit = (bit_cnt == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/cfg_loader.sv
// Configuration sequencer: streams one ROM bitstream slot into the fabric chain.
module cfg_loader
    import efpga_cfg_pkg::*;
#(
    parameter int WORD_W    = CFG_WORD_W,
    parameter int NUM_WORDS = CFG_NUM_WORDS,
    parameter int NUM_SLOTS = CFG_NUM_SLOTS
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          prog_btn,
    output logic                                          rom_rd,
    output logic [$clog2(NUM_SLOTS)+$clog2(NUM_WORDS)-1:0] rom_addr,
    input  logic [WORD_W-1:0]                             rom_data,
    output logic                                          cfg_shift,
    output logic                                          cfg_data,
    output logic                                          cfg_latch,
    output logic                                          fabric_en,
    output logic                                          busy,
    output logic [$clog2(NUM_SLOTS)-1:0]                  slot
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int WIDX_W = $clog2(NUM_WORDS);
    localparam int ADDR_W = SLOT_W + WIDX_W;

    cfg_state_t        state;
    cfg_state_t        next_state;
    logic              btn_q;
    logic              trigger;
    logic              idle_or_run;
    logic              last_word;
    logic [WIDX_W-1:0] word_idx;
    logic [ADDR_W-1:0] addr_hold;
    logic              shift_msb;
    logic              shift_last;

    // btn_q resets high so a button held through reset is not seen as a press.
    assign trigger     = prog_btn & ~btn_q;
    assign idle_or_run = (state == IDLE) || (state == RUN);
    assign last_word   = (word_idx == WIDX_W'(NUM_WORDS - 1));

    cfg_shifter #(
        .WORD_W(WORD_W)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load    (state == LOAD),
        .shift   (state == SHIFT),
        .word    (rom_data),
        .msb     (shift_msb),
        .last_bit(shift_last)
    );

    // State register; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Edge detect, word index, slot rotation and ROM address hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q     <= 1'b1;
            word_idx  <= '0;
            slot      <= '0;
            addr_hold <= '0;
        end else begin
            btn_q     <= prog_btn;
            addr_hold <= rom_addr;
            if (idle_or_run && trigger) begin
                word_idx <= '0;
            end else if ((state == SHIFT) && shift_last && !last_word) begin
                word_idx <= word_idx + WIDX_W'(1);
            end
            if (state == LATCH) begin
                slot <= slot + SLOT_W'(1);
            end
        end
    end

    // Next-state logic; presses while busy are dropped, not queued.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trigger) next_state = FETCH;
            FETCH:   next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (shift_last) next_state = last_word ? LATCH : FETCH;
            LATCH:   next_state = RUN;
            RUN:     if (trigger) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Moore outputs; the ROM address only changes while fetching.
    always_comb begin
        rom_rd    = 1'b0;
        rom_addr  = addr_hold;
        cfg_shift = 1'b0;
        cfg_data  = 1'b0;
        cfg_latch = 1'b0;
        fabric_en = 1'b0;
        busy      = 1'b0;
        case (state)
            FETCH: begin
                rom_rd   = 1'b1;
                rom_addr = {slot, word_idx};
                busy     = 1'b1;
            end
            LOAD: begin
                busy = 1'b1;
            end
            SHIFT: begin
                cfg_shift = 1'b1;
                cfg_data  = shift_msb;
                busy      = 1'b1;
            end
            LATCH: begin
                cfg_latch = 1'b1;
                busy      = 1'b1;
            end
            RUN: begin
                fabric_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader with a small ROM model and a bit scoreboard.
module tb_cfg_loader;

    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 4;
    localparam int NUM_SLOTS = 2;
    localparam int ADDR_W    = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              prog_btn = 1'b0;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data = '0;
    logic              cfg_shift;
    logic              cfg_data;
    logic              cfg_latch;
    logic              fabric_en;
    logic              busy;
    logic [0:0]        slot;

    logic [WORD_W-1:0] rom_mem [0:NUM_SLOTS*NUM_WORDS-1];
    logic              exp_q [$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int trig_cyc = 0;
    int latch_cyc = 0;
    int latch_count = 0;
    int busy_cycles = 0;
    int run_cycles = 0;
    int shift_seen = 0;
    int model_slot = 0;
    logic [WORD_W-1:0] cap = '0;

    cfg_loader #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .NUM_SLOTS(NUM_SLOTS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .prog_btn (prog_btn),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .cfg_shift(cfg_shift),
        .cfg_data (cfg_data),
        .cfg_latch(cfg_latch),
        .fabric_en(fabric_en),
        .busy     (busy),
        .slot     (slot)
    );

    always #5 clk = ~clk;

    // ROM model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_rd) rom_data <= rom_mem[rom_addr];
    end

    // Chain monitor: scoreboard every shifted bit, count latch/busy/run cycles.
    always @(negedge clk) begin
        logic exp_bit;
        if (cfg_latch) begin
            latch_count++;
            latch_cyc = cyc;
        end
        if (busy) busy_cycles++;
        if (fabric_en) run_cycles++;
        checks++;
        if (cfg_shift) begin
            if (shift_seen < WORD_W) cap = {cap[WORD_W-2:0], cfg_data};
            shift_seen++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL chain_bit: unexpected shift, got %b, expected no shift", cfg_data);
            end else begin
                exp_bit = exp_q.pop_front();
                if (cfg_data !== exp_bit)
                    $display("[TB] FAIL chain_bit: got %b expected %b at cycle %0d", cfg_data, exp_bit, cyc);
                else
                    passed++;
            end
        end else begin
            if (cfg_data !== 1'b0)
                $display("[TB] FAIL cfg_data_idle: got %b expected 0", cfg_data);
            else
                passed++;
        end
    end

    // Press the button for one edge and queue the expected chain bits of slot s.
    task automatic press(input int s);
        for (int w = 0; w < NUM_WORDS; w++)
            for (int b = WORD_W - 1; b >= 0; b--)
                exp_q.push_back(rom_mem[s*NUM_WORDS + w][b]);
        cap = '0;
        shift_seen = 0;
        prog_btn = 1'b1;
        @(posedge clk);
        #1;
        trig_cyc = cyc;
        prog_btn = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        prog_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({rom_rd, cfg_shift, cfg_latch, fabric_en, busy, rom_addr} !== 8'h00)
            $display("[TB] FAIL reset_outputs: got %b expected 00000000",
                     {rom_rd, cfg_shift, cfg_latch, fabric_en, busy, rom_addr});
        else passed++;
        checks++;
        if (slot !== 1'b0) $display("[TB] FAIL reset_slot: got %0d expected 0", slot);
        else passed++;
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_slot = 0;
    endtask

    task automatic test_basic_load();
        int latch0;
        latch0 = latch_count;
        press(model_slot);
        @(negedge clk);
        checks++;
        if ({rom_rd, busy, fabric_en, rom_addr} !== {1'b1, 1'b1, 1'b0, 3'b000})
            $display("[TB] FAIL fetch_cycle: got rd/busy/en/addr %b expected 1100000",
                     {rom_rd, busy, fabric_en, rom_addr});
        else passed++;
        repeat (71) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cfg_latch !== 1'b0) $display("[TB] FAIL latch_early: got %b expected 0 at k+72", cfg_latch);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (cfg_latch !== 1'b1) $display("[TB] FAIL latch_k73: got %b expected 1", cfg_latch);
        else passed++;
        @(posedge clk);
        #1;
        model_slot = (model_slot + 1) % NUM_SLOTS;
        @(negedge clk);
        checks++;
        if ({fabric_en, busy} !== 2'b10) $display("[TB] FAIL run_k74: got en/busy %b expected 10", {fabric_en, busy});
        else passed++;
        checks++;
        if (slot !== model_slot[0]) $display("[TB] FAIL slot_after_load: got %0d expected %0d", slot, model_slot);
        else passed++;
        checks++;
        if (cap !== 16'hF971) $display("[TB] FAIL first_word: got %h expected f971", cap);
        else passed++;
        checks++;
        if (latch_cyc - trig_cyc !== 72) $display("[TB] FAIL latch_latency: got %0d expected 72", latch_cyc - trig_cyc);
        else passed++;
        checks++;
        if (latch_count - latch0 !== 1) $display("[TB] FAIL latch_count_basic: got %0d expected 1", latch_count - latch0);
        else passed++;
    endtask

    task automatic test_slot_wrap();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_slot = 0;
        for (int i = 0; i < 3; i++) begin
            press(model_slot);
            @(negedge clk);
            checks++;
            if (rom_addr !== {model_slot[0], 2'b00})
                $display("[TB] FAIL wrap_addr%0d: got %b expected %b", i, rom_addr, {model_slot[0], 2'b00});
            else passed++;
            repeat (73) @(posedge clk);
            #1;
            model_slot = (model_slot + 1) % NUM_SLOTS;
            @(negedge clk);
            checks++;
            if ({fabric_en, slot} !== {1'b1, model_slot[0]})
                $display("[TB] FAIL wrap_slot%0d: got en/slot %b expected %b", i, {fabric_en, slot}, {1'b1, model_slot[0]});
            else passed++;
        end
    endtask

    task automatic test_busy_trigger();
        int latch0;
        latch0 = latch_count;
        press(model_slot);
        repeat (19) @(posedge clk);
        #1;
        prog_btn = 1'b1;
        @(posedge clk);
        #1;
        prog_btn = 1'b0;
        repeat (53) @(posedge clk);
        #1;
        model_slot = (model_slot + 1) % NUM_SLOTS;
        checks++;
        if (latch_cyc - trig_cyc !== 72) $display("[TB] FAIL busy_latch_time: got %0d expected 72", latch_cyc - trig_cyc);
        else passed++;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (latch_count - latch0 !== 1) $display("[TB] FAIL busy_latch_count: got %0d expected 1", latch_count - latch0);
        else passed++;
        @(negedge clk);
        checks++;
        if ({fabric_en, slot} !== {1'b1, model_slot[0]})
            $display("[TB] FAIL busy_slot: got en/slot %b expected %b", {fabric_en, slot}, {1'b1, model_slot[0]});
        else passed++;
    endtask

    task automatic test_reset_mid_load();
        int latch0;
        press(model_slot);
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        latch0 = latch_count;
        @(negedge clk);
        checks++;
        if ({rom_rd, cfg_shift, cfg_latch, fabric_en, busy, rom_addr, slot} !== 9'h000)
            $display("[TB] FAIL abort_outputs: got %b expected 000000000",
                     {rom_rd, cfg_shift, cfg_latch, fabric_en, busy, rom_addr, slot});
        else passed++;
        repeat (80) @(posedge clk);
        #1;
        checks++;
        if (latch_count !== latch0) $display("[TB] FAIL abort_no_latch: got %0d expected %0d", latch_count, latch0);
        else passed++;
        model_slot = 0;
        press(0);
        @(negedge clk);
        checks++;
        if (rom_addr !== 3'b000) $display("[TB] FAIL abort_reload_addr: got %b expected 000", rom_addr);
        else passed++;
        repeat (73) @(posedge clk);
        #1;
        model_slot = 1;
        checks++;
        if (cap !== rom_mem[0]) $display("[TB] FAIL abort_reload_word0: got %h expected %h", cap, rom_mem[0]);
        else passed++;
        @(negedge clk);
        checks++;
        if ({fabric_en, slot} !== 2'b11) $display("[TB] FAIL abort_reload_slot: got en/slot %b expected 11", {fabric_en, slot});
        else passed++;
    endtask

    task automatic test_held_button();
        int busy0;
        int latch0;
        reset = 1'b1;
        prog_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        busy0 = busy_cycles;
        latch0 = latch_count;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (busy_cycles - busy0 !== 0) $display("[TB] FAIL held_no_load: got %0d busy cycles expected 0", busy_cycles - busy0);
        else passed++;
        @(negedge clk);
        checks++;
        if ({fabric_en, slot} !== 2'b00 || latch_count !== latch0)
            $display("[TB] FAIL held_idle: got en/slot %b latches %0d expected 00 and %0d", {fabric_en, slot}, latch_count, latch0);
        else passed++;
        prog_btn = 1'b0;
        @(posedge clk);
        #1;
        model_slot = 0;
        press(0);
        repeat (73) @(posedge clk);
        #1;
        model_slot = 1;
        @(negedge clk);
        checks++;
        if ({fabric_en, slot} !== 2'b11) $display("[TB] FAIL held_repress: got en/slot %b expected 11", {fabric_en, slot});
        else passed++;
    endtask

    task automatic test_reprogram_from_run();
        int run0;
        press(model_slot);
        run0 = run_cycles;
        @(negedge clk);
        checks++;
        if (fabric_en !== 1'b0) $display("[TB] FAIL reprog_en_drop: got %b expected 0", fabric_en);
        else passed++;
        repeat (72) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cfg_latch !== 1'b1) $display("[TB] FAIL reprog_latch: got %b expected 1", cfg_latch);
        else passed++;
        @(posedge clk);
        #1;
        model_slot = (model_slot + 1) % NUM_SLOTS;
        checks++;
        if (run_cycles - run0 !== 0) $display("[TB] FAIL reprog_en_low: got %0d enabled cycles expected 0", run_cycles - run0);
        else passed++;
        @(negedge clk);
        checks++;
        if ({fabric_en, slot} !== {1'b1, model_slot[0]})
            $display("[TB] FAIL reprog_run: got en/slot %b expected %b", {fabric_en, slot}, {1'b1, model_slot[0]});
        else passed++;
    endtask

    task automatic test_scoreboard_drained();
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() !== 0) $display("[TB] FAIL scoreboard_drain: got %0d bits left expected 0", exp_q.size());
        else passed++;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rom_mem[0] = 16'hF971; rom_mem[1] = 16'h1234; rom_mem[2] = 16'hA5C3; rom_mem[3] = 16'h0FF0;
        rom_mem[4] = 16'h8001; rom_mem[5] = 16'h7E7E; rom_mem[6] = 16'hC0DE; rom_mem[7] = 16'h3B29;
        test_reset();
        test_basic_load();
        test_slot_wrap();
        test_busy_trigger();
        test_reset_mid_load();
        test_held_button();
        test_reprogram_from_run();
        test_scoreboard_drained();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
